// File: rtl/touch_adc_ctrl.sv
// touch_adc_ctrl: serial front end for a 12-bit AD7843-class touch ADC.
// While the pen is down it repeatedly converts X then Y inside one CS-low
// window, then publishes the pair with a one-cycle new_coord strobe.
// Optional feature macro: TOUCH_AVG_EN. When defined, each published pair
// is the truncated average of 4 consecutive valid pairs.
module touch_adc_ctrl #(
  parameter int         CLK_DIV  = 25,
  parameter int         SCAN_GAP = 50000,
  parameter logic [7:0] X_CMD    = 8'h92,
  parameter logic [7:0] Y_CMD    = 8'hD2
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iPENIRQ_n,
  input  logic        iADC_DOUT,
  output logic        oADC_DIN,
  output logic        oADC_DCLK,
  output logic        oADC_CS_n,
  output logic [11:0] oX_COORD,
  output logic [11:0] oY_COORD,
  output logic        oNEW_COORD,
  output logic        oTOUCH_IRQ
);

  typedef enum logic [2:0] {IDLE, GAP, XFER_X, XFER_Y, UPDATE} state_t;

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(SCAN_GAP - 1);
  localparam logic [4:0]  PER_LAST = 5'd23;
  localparam logic [4:0]  DATA_LO  = 5'd9;
  localparam logic [4:0]  DATA_HI  = 5'd20;

  state_t      state, state_next;
  logic        pen_meta, pen, dout_meta, dout_sync;
  logic [15:0] gap_cnt;
  logic [7:0]  div_cnt;
  logic [4:0]  per_cnt;
  logic        dclk_q, din_q, cs_n_q, din_next;
  logic [11:0] x_shift, y_shift;
  logic [7:0]  cmd_byte;
  logic        xfer, half_done, dclk_rise, dclk_fall, frame_end;

  // Two-flop synchronizers for the asynchronous pen interrupt and ADC data.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, exactly as the hardware does.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      pen_meta  <= 1'b0;
      pen       <= 1'b0;
      dout_meta <= 1'b0;
      dout_sync <= 1'b0;
    end else begin
      pen_meta  <= ~iPENIRQ_n;
      pen       <= pen_meta;
      dout_meta <= iADC_DOUT;
      dout_sync <= dout_meta;
    end
  end

  assign oTOUCH_IRQ = pen;

  // DCLK edge decode: each half-period lasts CLK_DIV cycles; a period is a
  // low half followed by a high half, so a frame ends on a falling edge.
  assign xfer      = (state == XFER_X) || (state == XFER_Y);
  assign half_done = xfer && (div_cnt == DIV_LAST);
  assign dclk_rise = half_done && !dclk_q;
  assign dclk_fall = half_done && dclk_q;
  assign frame_end = dclk_fall && (per_cnt == PER_LAST);
  assign cmd_byte  = (state == XFER_Y) ? Y_CMD : X_CMD;

  // State register.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic and the next command bit to put on DIN.
  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    din_next   = din_q;
    case (state)
      IDLE:    if (pen) state_next = GAP;
      GAP: begin
        if (!pen)                     state_next = IDLE;
        else if (gap_cnt == GAP_LAST) state_next = XFER_X;
      end
      XFER_X:  if (frame_end) state_next = XFER_Y;
      XFER_Y:  if (frame_end) state_next = UPDATE;
      UPDATE:  state_next = pen ? GAP : IDLE;
      default: state_next = IDLE;
    endcase

    // Command bit 7 goes out with the CS fall; later bits change only on
    // DCLK falling edges, which open the next period.
    if (state == GAP && state_next == XFER_X) begin
      din_next = X_CMD[7];
    end else if (dclk_fall) begin
      if (frame_end)            din_next = (state == XFER_X) ? Y_CMD[7] : 1'b0;
      else if (per_cnt < 5'd7)  din_next = cmd_byte[3'd6 - per_cnt[2:0]];
      else                      din_next = 1'b0;
    end
  end

  // Gap counter, serial clock generation, chip select and data capture.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      gap_cnt <= '0;
      div_cnt <= '0;
      per_cnt <= '0;
      dclk_q  <= 1'b0;
      din_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      x_shift <= '0;
      y_shift <= '0;
    end else begin
      gap_cnt <= (state == GAP && state_next == GAP) ? gap_cnt + 16'd1 : '0;

      if (xfer) div_cnt <= half_done ? '0 : div_cnt + 8'd1;
      else      div_cnt <= '0;

      if (half_done) dclk_q <= ~dclk_q;
      else if (!xfer) dclk_q <= 1'b0;

      if (dclk_fall)  per_cnt <= frame_end ? '0 : per_cnt + 5'd1;
      else if (!xfer) per_cnt <= '0;

      // CS is low exactly while the FSM is in one of the two frames.
      cs_n_q <= !((state_next == XFER_X) || (state_next == XFER_Y));
      din_q  <= din_next;

      if (dclk_rise && per_cnt >= DATA_LO && per_cnt <= DATA_HI) begin
        if (state == XFER_X) x_shift <= {x_shift[10:0], dout_sync};
        else                 y_shift <= {y_shift[10:0], dout_sync};
      end
    end
  end

  assign oADC_DCLK = dclk_q;
  assign oADC_DIN  = din_q;
  assign oADC_CS_n = cs_n_q;

`ifdef TOUCH_AVG_EN
  logic [13:0] x_acc, y_acc, x_sum, y_sum;
  logic [1:0]  avg_cnt;

  assign x_sum = x_acc + {2'b00, x_shift};
  assign y_sum = y_acc + {2'b00, y_shift};

  // Accumulate 4 valid pairs, then publish the truncated average.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oX_COORD   <= '0;
      oY_COORD   <= '0;
      oNEW_COORD <= 1'b0;
      x_acc      <= '0;
      y_acc      <= '0;
      avg_cnt    <= '0;
    end else begin
      oNEW_COORD <= 1'b0;
      if (state == UPDATE && pen) begin
        if (avg_cnt == 2'd3) begin
          oX_COORD   <= x_sum[13:2];
          oY_COORD   <= y_sum[13:2];
          oNEW_COORD <= 1'b1;
          x_acc      <= '0;
          y_acc      <= '0;
          avg_cnt    <= '0;
        end else begin
          x_acc   <= x_sum;
          y_acc   <= y_sum;
          avg_cnt <= avg_cnt + 2'd1;
        end
      end else if (state == IDLE) begin
        x_acc   <= '0;
        y_acc   <= '0;
        avg_cnt <= '0;
      end
    end
  end
`else
  // Publish each pair whose UPDATE still sees the pen down.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oX_COORD   <= '0;
      oY_COORD   <= '0;
      oNEW_COORD <= 1'b0;
    end else begin
      oNEW_COORD <= 1'b0;
      if (state == UPDATE && pen) begin
        oX_COORD   <= x_shift;
        oY_COORD   <= y_shift;
        oNEW_COORD <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_touch_adc_ctrl.sv
// Self-checking bench for touch_adc_ctrl: an ADC model serves random or
// queued samples, and a pair-level reference model predicts published
// coordinates (averaged over 4 pairs when TOUCH_AVG_EN is defined).
module tb_touch_adc_ctrl;
  localparam int CD   = 5;
  localparam int GAP  = 300;
  localparam int WIN  = 96 * CD;
  localparam int PAIR = 1 + GAP + WIN;
`ifdef TOUCH_AVG_EN
  localparam int N = 4;
`else
  localparam int N = 1;
`endif

  typedef struct { logic [11:0] x; logic [11:0] y; } pair_t;
  typedef struct { int cyc; logic [11:0] x; logic [11:0] y; } strobe_t;

  logic        iCLK = 1'b0, iRST_n = 1'b0, iPENIRQ_n = 1'b1, iADC_DOUT = 1'b0;
  logic        oADC_DIN, oADC_DCLK, oADC_CS_n, oNEW_COORD, oTOUCH_IRQ;
  logic [11:0] oX_COORD, oY_COORD;

  touch_adc_ctrl #(.CLK_DIV(CD), .SCAN_GAP(GAP), .X_CMD(8'h92), .Y_CMD(8'hD2)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iPENIRQ_n(iPENIRQ_n), .iADC_DOUT(iADC_DOUT),
    .oADC_DIN(oADC_DIN), .oADC_DCLK(oADC_DCLK), .oADC_CS_n(oADC_CS_n),
    .oX_COORD(oX_COORD), .oY_COORD(oY_COORD), .oNEW_COORD(oNEW_COORD),
    .oTOUCH_IRQ(oTOUCH_IRQ)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(string tag, int obs, int lo, int hi);
    checks++;
    assert (obs >= lo && obs <= hi) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Reference model state: samples to serve, pairs pending average, results.
  pair_t   val_q[$], acc[$], exp_q[$];
  strobe_t sq[$];
  bit      valid_pair = 1'b1;

  task automatic model_push(pair_t p);
    int sx, sy;
    pair_t e;
    acc.push_back(p);
    if (acc.size() == N) begin
      sx = 0; sy = 0;
      foreach (acc[i]) begin sx += int'(acc[i].x); sy += int'(acc[i].y); end
      e.x = 12'(sx / N);
      e.y = 12'(sy / N);
      exp_q.push_back(e);
      acc.delete();
    end
  endtask

  // ADC model: periods counted from CS fall and DCLK falling edges.
  logic       prev_cs = 1'b1, prev_dclk = 1'b0;
  bit         in_pair = 1'b0;
  int         per = 0, frame = 0, cs_len = 0, last_cs_len = 0, cs_falls = 0, pairs_done = 0;
  logic [7:0] cmd_sh[2];
  logic [7:0] last_cmd_x = 8'h00, last_cmd_y = 8'h00;
  pair_t      cur;

  task automatic drive_dout();
    logic [11:0] w;
    w = (frame == 0) ? cur.x : cur.y;
    if (frame < 2 && per >= 9 && per <= 20) iADC_DOUT = w[20 - per];
    else                                    iADC_DOUT = 1'b0;
  endtask

  always @(negedge iCLK) begin
    if (!iRST_n) begin
      in_pair = 1'b0; iADC_DOUT = 1'b0; prev_cs = 1'b1; prev_dclk = 1'b0;
    end else begin
      if (prev_cs && !oADC_CS_n) begin
        cs_falls++; in_pair = 1'b1; per = 0; frame = 0; cs_len = 0;
        cmd_sh[0] = 8'h00; cmd_sh[1] = 8'h00;
        if (val_q.size() > 0) cur = val_q.pop_front();
        else begin
          cur.x = 12'($urandom_range(0, 4095));
          cur.y = 12'($urandom_range(0, 4095));
        end
        drive_dout();
      end
      if (!oADC_CS_n) cs_len++;
      if (in_pair && !prev_dclk && oADC_DCLK && per < 8 && frame < 2)
        cmd_sh[frame] = {cmd_sh[frame][6:0], oADC_DIN};
      if (in_pair && prev_dclk && !oADC_DCLK) begin
        per++;
        if (per == 24) begin per = 0; frame++; end
        drive_dout();
      end
      if (in_pair && !prev_cs && oADC_CS_n) begin
        in_pair = 1'b0; last_cs_len = cs_len;
        last_cmd_x = cmd_sh[0]; last_cmd_y = cmd_sh[1];
        pairs_done++;
        if (valid_pair) model_push(cur);
      end
      prev_cs = oADC_CS_n; prev_dclk = oADC_DCLK;
    end
  end

  // Strobe recorder.
  always @(negedge iCLK) begin
    strobe_t s;
    if (iRST_n && oNEW_COORD) begin
      s.cyc = cyc; s.x = oX_COORD; s.y = oY_COORD;
      sq.push_back(s);
    end
  end

  task automatic wait_cycles(int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic wait_strobes(string tag, int n, int budget);
    int k = 0;
    while (sq.size() < n && k < budget) begin @(negedge iCLK); k++; end
    check({tag, "_strobe_count"}, sq.size(), n);
  endtask

  task automatic wait_frame_point(string tag, int f, int p, int budget);
    int k = 0;
    while (!(in_pair && frame == f && per == p) && k < budget) begin @(negedge iCLK); k++; end
    check({tag, "_reached"}, int'(in_pair && frame == f && per == p), 1);
  endtask

  task automatic check_pub(string tag);
    strobe_t s;
    pair_t   e;
    check({tag, "_avail"}, int'(sq.size() > 0 && exp_q.size() > 0), 1);
    if (sq.size() > 0 && exp_q.size() > 0) begin
      s = sq.pop_front();
      e = exp_q.pop_front();
      check({tag, "_x"}, s.x, e.x);
      check({tag, "_y"}, s.y, e.y);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_cs_n"}, oADC_CS_n, 1);
    check({tag, "_dclk"}, oADC_DCLK, 0);
    check({tag, "_din"},  oADC_DIN, 0);
    check({tag, "_x"},    oX_COORD, 0);
    check({tag, "_y"},    oY_COORD, 0);
    check({tag, "_new"},  oNEW_COORD, 0);
    check({tag, "_irq"},  oTOUCH_IRQ, 0);
  endtask

  initial begin
    pair_t p;
    logic [11:0] hold_x, hold_y;
    int falls0, base, rel;

    // Reset state.
    wait_cycles(3);
    check_reset_outputs("reset");
    iRST_n = 1'b1;
    wait_cycles(2);

    // Short touch: pen released before the gap expires.
    iPENIRQ_n = 1'b0;
    wait_cycles(GAP - 10);
    iPENIRQ_n = 1'b1;
    wait_cycles(GAP + 20);
    check("short_cs_falls", cs_falls, 0);
    check("short_strobes", sq.size(), 0);
    check("short_x", oX_COORD, 0);
    check("short_y", oY_COORD, 0);
    check("short_cs_n", oADC_CS_n, 1);

    // Basic conversion with fixed samples.
    p.x = 12'hABC; p.y = 12'h123;
    repeat (N) val_q.push_back(p);
    iPENIRQ_n = 1'b0;
    wait_cycles(1);
    check("irq_lat_1cyc", oTOUCH_IRQ, 0);
    wait_cycles(2);
    check("irq_lat_3cyc", oTOUCH_IRQ, 1);
    wait_strobes("basic", 1, N * PAIR + GAP + 100);
    iPENIRQ_n = 1'b1;
    check("basic_cmd_x", last_cmd_x, 8'h92);
    check("basic_cmd_y", last_cmd_y, 8'hD2);
    check("basic_cs_len", last_cs_len, WIN);
    check("basic_fixed_x", oX_COORD, 12'hABC);
    check_pub("basic");
    wait_cycles(1);
    check("basic_pulse_width", oNEW_COORD, 0);
    wait_cycles(GAP + 50);
    check("basic_no_extra", sq.size(), 0);
    check("basic_idle_cs_n", oADC_CS_n, 1);

    // Held pen, random samples: three publications at a fixed spacing.
    iPENIRQ_n = 1'b0;
    wait_strobes("held", 3, 3 * N * PAIR + GAP + 200);
    iPENIRQ_n = 1'b1;
    if (sq.size() >= 3) begin
      check("held_spacing_1", sq[1].cyc - sq[0].cyc, N * PAIR);
      check("held_spacing_2", sq[2].cyc - sq[1].cyc, N * PAIR);
    end
    check_pub("held_0");
    check_pub("held_1");
    check_pub("held_2");
    wait_cycles(GAP + 50);

    // Release during the Y frame: frame completes, nothing is published.
    hold_x = oX_COORD; hold_y = oY_COORD;
    iPENIRQ_n = 1'b0;
    wait_frame_point("release", 1, 5, GAP + PAIR);
    iPENIRQ_n = 1'b1;
    valid_pair = 1'b0;
    acc.delete();
    falls0 = cs_falls;
    base = pairs_done;
    wait_cycles(WIN);
    check("release_pair_done", pairs_done - base, 1);
    check("release_cs_len", last_cs_len, WIN);
    wait_cycles(2 * GAP);
    check("release_strobes", sq.size(), 0);
    check("release_hold_x", oX_COORD, hold_x);
    check("release_hold_y", oY_COORD, hold_y);
    check("release_idle", cs_falls - falls0, 0);
    valid_pair = 1'b1;

    // Sample sequence 100,101,102,104 (averages to 101 with the option).
    p.x = 12'd100; p.y = 12'd200; val_q.push_back(p);
    p.x = 12'd101; p.y = 12'd201; val_q.push_back(p);
    p.x = 12'd102; p.y = 12'd202; val_q.push_back(p);
    p.x = 12'd104; p.y = 12'd204; val_q.push_back(p);
    base = pairs_done;
    iPENIRQ_n = 1'b0;
`ifdef TOUCH_AVG_EN
    begin
      int k = 0;
      while (pairs_done - base < 3 && k < 4 * PAIR) begin @(negedge iCLK); k++; end
    end
    wait_cycles(10);
    check("avg_no_early_strobe", sq.size(), 0);
`endif
    wait_strobes("samples", 4 / N, 4 * PAIR + GAP + 200);
    iPENIRQ_n = 1'b1;
`ifdef TOUCH_AVG_EN
    if (sq.size() > 0) begin
      check("avg_x_101", sq[0].x, 12'd101);
      check("avg_y_201", sq[0].y, 12'd201);
    end
`endif
    repeat (4 / N) check_pub("samples");
    wait_cycles(GAP + 50);

    // Reset in period 12 of the X frame.
    iPENIRQ_n = 1'b0;
    wait_frame_point("rst", 0, 12, GAP + PAIR);
    iRST_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    acc.delete();
    wait_cycles(3);
    iRST_n = 1'b1;
    rel = cyc;
    check("rst_no_strobe", sq.size(), 0);
    wait_strobes("rst_recover", 1, N * PAIR + GAP + 200);
    if (sq.size() > 0)
      check_range("rst_first_strobe_delay", sq[0].cyc - rel,
                  (N - 1) * PAIR + GAP + WIN + 3, (N - 1) * PAIR + GAP + WIN + 5);
    check_pub("rst_recover");
    iPENIRQ_n = 1'b1;
    wait_cycles(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
